// File: rtl/blink_pkg.sv
// Shared constants for the blink timing stage: rate width, 12 MHz defaults
// and the prescaler width helper.
package blink_pkg;

  localparam int RATE_W        = 2;
  localparam int DEF_BASE_DIV  = 12000;
  localparam int DEF_DB_CYCLES = 120000;

  // Wide enough for the slowest period, 8*BASE_DIV cycles (count reaches P-1).
  function automatic int presc_width(input int base_div);
    return $clog2(8 * base_div);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser and counting debouncer for the active-low button;
// emits a registered one-cycle press pulse on each accepted press.
module btn_debounce
  import blink_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press,
  output logic step
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync_q1;
  logic          sync;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  // High in the cycle after the accepted level falls; the rate step and the
  // registered press pulse both take effect on the edge that ends this cycle.
  assign step = stable_d & ~stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1  <= 1'b1;
      sync     <= 1'b1;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync_q1  <= btn_n;
      sync     <= sync_q1;
      stable_d <= stable;
      press    <= step;
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/blink_rate_ctrl.sv
// Button-selected blink rate and tick prescaler feeding the LED counter;
// TICK period is BASE_DIV << RATE clock cycles.
module blink_rate_ctrl
  import blink_pkg::*;
#(
  parameter int BASE_DIV  = DEF_BASE_DIV,
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int INIT_RATE = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              BTN_N,
  input  logic              EN,
  output logic              TICK,
  output logic [RATE_W-1:0] RATE,
  output logic              PRESS
);

  localparam int CW = presc_width(BASE_DIV);

  logic          step;
  logic [CW-1:0] cnt;
  logic [CW-1:0] last;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk  (CLK),
    .rst_n(RST_N),
    .btn_n(BTN_N),
    .press(PRESS),
    .step (step)
  );

  assign last = CW'((BASE_DIV << RATE) - 1);

  // A rate step outranks a terminal count so the new period starts cleanly.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      TICK <= 1'b0;
      RATE <= RATE_W'(INIT_RATE);
      cnt  <= '0;
    end else if (step) begin
      TICK <= 1'b0;
      RATE <= RATE + 1'b1;
      cnt  <= '0;
    end else if (EN) begin
      if (cnt == last) begin
        cnt  <= '0;
        TICK <= 1'b1;
      end else begin
        cnt  <= cnt + CW'(1);
        TICK <= 1'b0;
      end
    end else begin
      TICK <= 1'b0;
    end
  end

endmodule

// File: doc/blink_rate_ctrl.md
Name: blink_rate_ctrl

Overview:
Upstream timing stage for the iCEBreaker blink/LED counter. It debounces the active-low user button (BTN_N), which steps a 2-bit rate select. It also generates a one-cycle TICK enable at a period chosen by that rate. The downstream LED counter increments only on TICK, so the button changes blink speed without resynthesis.

Parameters:
BASE_DIV, 12000, TICK period in CLK cycles at RATE=0 (1 kHz at 12 MHz); must be >= 2
DB_CYCLES, 120000, consecutive stable synchronised samples required to accept a button level change (10 ms at 12 MHz); must be >= 2
INIT_RATE, 0, RATE value after reset (0..3)

Ports:
CLK  input  1  system clock (12 MHz on board)
RST_N  input  1  asynchronous active-low reset
BTN_N  input  1  raw user button, low = pressed, asynchronous to CLK
EN  input  1  high = prescaler runs; low = prescaler frozen
TICK  output  1  one-cycle pulse, period BASE_DIV<<RATE cycles
RATE  output  2  current rate select
PRESS  output  1  one-cycle pulse per accepted button press

Behaviour:
- Reset (RST_N low, asynchronous assert, synchronous release by CLK edge):
  - TICK=0, PRESS=0, RATE=INIT_RATE.
  - Prescaler count=0, debounce count=0.
  - Both synchroniser flops and the stable level = 1 (released).
- Synchroniser: two flops on BTN_N; the second flop output is "sync".
- Debounce:
  - If sync == stable, debounce count <= 0.
  - Else, if count == DB_CYCLES-1: stable <= sync and count <= 0.
  - Otherwise count++.
  - Any bounce back to the stable level before terminal restarts the count.
- PRESS: registered; 1 in the cycle after stable goes 1->0. A release (0->1) produces no pulse.
- Latency: BTN_N low (held) first sampled at edge k gives PRESS high after edge k+DB_CYCLES+2, for exactly one cycle.
- Rate step on PRESS (same cycle PRESS is generated internally):
  - RATE <= RATE+1, modulo 4 (3 wraps to 0).
  - Prescaler count <= 0.
  - No TICK in that cycle.
- Prescaler: period P = BASE_DIV << RATE (BASE_DIV, 2*BASE_DIV, 4*BASE_DIV, 8*BASE_DIV).
  - Counter width = clog2(8*BASE_DIV).
  - EN=1: if count == P-1, count <= 0 and TICK <= 1; else count++ and TICK <= 0.
  - EN=0: count holds, TICK <= 0. Resuming EN continues from the held count.
- Simultaneous rate step and terminal count: the rate step wins (count cleared, TICK=0). The first TICK at the new rate comes P_new cycles later.
- TICK never asserts on consecutive cycles; TICK and PRESS are glitch-free registered outputs.
- Reset mid-count or mid-debounce: all state returns to reset values immediately. A button held through reset release registers as a new press after the full debounce latency.

Decomposition:
- Shared package blink_pkg holds:
  - RATE width constant (2).
  - Default BASE_DIV and DB_CYCLES for 12 MHz.
  - Function computing prescaler width.
- Sub-module btn_debounce contains the synchroniser, debounce counter, stable level and PRESS edge pulse, with parameter DB_CYCLES.
- The top module holds the RATE register and the prescaler.

Test Plan:
(sim params BASE_DIV=4, DB_CYCLES=3, INIT_RATE=0)
1. Reset release, EN=1, BTN_N=1 -> TICK every 4 cycles; first TICK 4 cycles after release; RATE=0, PRESS never asserts.
2. BTN_N low at edge k, held -> PRESS high after edge k+5 for one cycle; RATE 0->1; TICK period becomes 8; no TICK in the step cycle.
3. BTN_N pulses low for 2 cycles then returns high (bounce) -> no PRESS, RATE unchanged. Then four clean presses -> RATE sequence 1,2,3,0, with periods 8,16,32,4.
4. EN low for 10 cycles at prescaler count 2 -> no TICK during the hold; after EN high, TICK arrives after 2 more cycles at RATE=0.
5. PRESS timed to coincide with count == P-1 -> TICK suppressed that cycle; next TICK exactly P_new cycles later.
6. RST_N low mid-period with BTN_N held low -> outputs reset immediately; after release, RATE=INIT_RATE and PRESS fires DB_CYCLES+2 cycles after the first sampling edge.
